// File: rtl/a2d_sequencer.sv
// a2d_sequencer: round-robin A2D sampler (ch 0/4/5), two SPI transactions per sample.
// Optional macro A2D_AVG_EN: each update averages the new sample with the previous one.
module a2d_sequencer #(
  parameter int GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] batt,
  output logic        vld,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    GAP,
    READ
  } state_t;

  state_t      state;
  logic [2:0]  ch;
  logic [3:0]  gap_cnt;
  logic [2:0]  sel;
  logic [11:0] sample;
  logic [11:0] upd_v;
  logic        capture;
  logic        unused_hi;

  assign busy      = (state != IDLE);
  assign sample    = rd_data[11:0];
  assign unused_hi = ^rd_data[15:12];
  assign capture   = (state == READ) && done;
  assign sel       = {ch == 3'd5, ch == 3'd4, ch == 3'd0};

`ifdef A2D_AVG_EN
  logic [2:0]  seen;
  logic [11:0] cur_v;
  logic [12:0] sum;

  always_comb begin
    cur_v = batt;
    unique case (1'b1)
      sel[0]:  cur_v = lft_ld;
      sel[1]:  cur_v = rght_ld;
      default: cur_v = batt;
    endcase
  end

  assign sum   = {1'b0, cur_v} + {1'b0, sample} + 13'd1;
  assign upd_v = ((seen & sel) != 3'b000) ? 12'(sum >> 1) : sample;

  // first sample per channel loads raw so reset zeros never bias the average
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen <= 3'b000;
    end else if (capture) begin
      seen <= seen | sel;
    end
  end
`else
  assign upd_v = sample;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ch      <= 3'd0;
      gap_cnt <= 4'd0;
      wrt     <= 1'b0;
      vld     <= 1'b0;
      cmd     <= 16'h0000;
      lft_ld  <= 12'h000;
      rght_ld <= 12'h000;
      batt    <= 12'h000;
    end else begin
      wrt <= 1'b0;
      vld <= 1'b0;
      unique case (state)
        IDLE: begin
          if (nxt) begin
            wrt   <= 1'b1;
            cmd   <= {2'b00, ch, 11'h000};
            state <= CMD;
          end
        end
        CMD: begin
          if (done) begin
            gap_cnt <= GAP_CYCLES[3:0];
            state   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt <= 4'd1) begin
            gap_cnt <= 4'd0;
            wrt     <= 1'b1;
            state   <= READ;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        READ: begin
          if (done) begin
            vld   <= 1'b1;
            state <= IDLE;
            unique case (1'b1)
              sel[0]: begin
                lft_ld <= upd_v;
                ch     <= 3'd4;
              end
              sel[1]: begin
                rght_ld <= upd_v;
                ch      <= 3'd5;
              end
              default: begin
                batt <= upd_v;
                ch   <= 3'd0;
              end
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_a2d_sequencer.sv
// tb_a2d_sequencer: random nxt/SPI-latency stimulus, queue scoreboard on vld and wrt.
// Build with +define+A2D_AVG_EN to check the averaging variant.
module tb_a2d_sequencer;

  localparam int GAP = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        nxt = 1'b0;
  logic        done = 1'b0;
  logic [15:0] rd_data = 16'h0000;
  logic        wrt;
  logic [15:0] cmd;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic [11:0] batt;
  logic        vld;
  logic        busy;

  a2d_sequencer #(.GAP_CYCLES(GAP)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .nxt     (nxt),
    .wrt     (wrt),
    .cmd     (cmd),
    .done    (done),
    .rd_data (rd_data),
    .lft_ld  (lft_ld),
    .rght_ld (rght_ld),
    .batt    (batt),
    .vld     (vld),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [35:0] act,
                     input logic [35:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  int          chans[3] = '{0, 4, 5};
  logic [11:0] dir_data[4] = '{12'hC00, 12'h456, 12'hABC, 12'h123};

  bit          m_busy, pend_idle, pend_gap, in_gap;
  int          ptr;
  logic [11:0] m_reg[3];
  bit          m_seen[3];
  bit          spi_act, spi_read, last_read_wrt;
  int          spi_left, tx_phase, done1_cyc;
  logic [15:0] cur_cmd;
  int          accepted = 0, wrts = 0, vlds = 0, req_idx = 0;
  logic [15:0] cmd_q[$];
  logic [15:0] data_q[$];
  logic [35:0] exp_q[$];
  int          vcyc_q[$];

  task automatic model_reset();
    m_busy = 0; pend_idle = 0; pend_gap = 0; in_gap = 0;
    ptr = 0; spi_act = 0; spi_read = 0; spi_left = 0; tx_phase = 0;
    for (int i = 0; i < 3; i++) begin
      m_reg[i] = 12'h000;
      m_seen[i] = 0;
    end
    cmd_q.delete(); data_q.delete(); exp_q.delete(); vcyc_q.delete();
  endtask

  task automatic step(input bit allow_nxt);
    logic [11:0] d;
    @(posedge clk); #1;
    if (pend_idle) begin m_busy = 0; pend_idle = 0; end
    if (pend_gap) begin in_gap = 1; pend_gap = 0; end
    chk("busy", busy, m_busy);
    if (wrt) in_gap = 0;

    done = 1'b0;
    rd_data = 16'($urandom);
    if (spi_act) begin
      chk("cmd_hold", cmd, cur_cmd);
      spi_left--;
      if (spi_left == 0) begin
        done = 1'b1;
        spi_act = 0;
        if (spi_read) begin
          rd_data = data_q.pop_front();
          vcyc_q.push_back(cyc + 1);
          pend_idle = 1;
        end else begin
          done1_cyc = cyc;
          pend_gap = 1;
        end
      end
    end else if ((in_gap || !m_busy) && $urandom_range(0, 5) == 0) begin
      done = 1'b1;
    end

    if (wrt) begin
      wrts++;
      chk("wrt_overlap", spi_act, 0);
      if (cmd_q.size() == 0) begin
        total++; bad++;
        $display("FAIL wrt_unexpected: got wrt=1 cmd=%h want no strobe", cmd);
      end else begin
        chk("cmd", cmd, cmd_q.pop_front());
      end
      if (tx_phase == 1) begin
        chk("gap", cyc - done1_cyc, GAP + 1);
        last_read_wrt = 1;
      end
      spi_act = 1;
      spi_read = (tx_phase == 1);
      spi_left = $urandom_range(1, 4);
      cur_cmd = cmd;
      tx_phase = (tx_phase == 1) ? 0 : 1;
    end

    nxt = 1'b0;
    if (allow_nxt && $urandom_range(0, 2) == 0) begin
      nxt = 1'b1;
      if (!m_busy) begin
        m_busy = 1;
        cmd_q.push_back({2'b00, 3'(chans[ptr]), 11'h000});
        cmd_q.push_back({2'b00, 3'(chans[ptr]), 11'h000});
        d = (req_idx < 4) ? dir_data[req_idx] : 12'($urandom);
        req_idx++;
        data_q.push_back({4'($urandom), d});
`ifdef A2D_AVG_EN
        if (m_seen[ptr])
          m_reg[ptr] = 12'((int'(m_reg[ptr]) + int'(d) + 1) / 2);
        else
          m_reg[ptr] = d;
        m_seen[ptr] = 1;
`else
        m_reg[ptr] = d;
`endif
        exp_q.push_back({m_reg[0], m_reg[1], m_reg[2]});
        ptr = (ptr + 1) % 3;
        accepted++;
      end
    end
  endtask

  logic [35:0] e;
  always @(negedge clk) begin
    if (rst_n && vld === 1'b1) begin
      vlds++;
      if (exp_q.size() == 0 || vcyc_q.size() == 0) begin
        total++; bad++;
        $display("FAIL vld_unexpected: got vld=1 want no pulse");
      end else begin
        e = exp_q.pop_front();
        chk("lft_ld", lft_ld, e[35:24]);
        chk("rght_ld", rght_ld, e[23:12]);
        chk("batt", batt, e[11:0]);
        chk("vld_cycle", cyc, vcyc_q.pop_front());
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_lft"}, lft_ld, 0);
    chk({tag, "_rght"}, rght_ld, 0);
    chk({tag, "_batt"}, batt, 0);
    chk({tag, "_cmd"}, cmd, 0);
    chk({tag, "_wrt"}, wrt, 0);
    chk({tag, "_vld"}, vld, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    repeat (300) step(1);

    last_read_wrt = 0;
    k = 0;
    while (!last_read_wrt && k < 400) begin
      step(1);
      k++;
    end
    chk("reach_read", last_read_wrt, 1);
    rst_n = 1'b0;
    nxt = 1'b0;
    done = 1'b0;
    #1;
    chk_zero("mid_reset");
    if (last_read_wrt) begin
      accepted--;
      wrts -= 2;
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    repeat (300) step(1);

    k = 0;
    while ((m_busy || spi_act) && k < 200) begin
      step(0);
      k++;
    end
    step(0);
    step(0);
    chk("drained", m_busy, 0);
    chk("pending_exp", exp_q.size(), 0);
    chk("vld_count", vlds, accepted);
    chk("wrt_count", wrts, 2 * accepted);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/a2d_sequencer.md
A2D_SEQUENCER -- requirements
Module: a2d_sequencer

Interface
REQ-001 Parameter GAP_CYCLES, default 2, idle clk cycles between the command transaction's done and the read transaction's wrt (legal 1..15).
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 nxt  input  1  single-cycle strobe requesting conversion of the next channel in rotation.
REQ-005 wrt  output  1  single-cycle strobe to the SPI master starting a 16-bit transaction.
REQ-006 cmd  output  16  command word sent to the SPI master.
REQ-007 done  input  1  single-cycle strobe from the SPI master: transaction complete.
REQ-008 rd_data  input  16  word returned by the SPI master; valid in the cycle done is high.
REQ-009 lft_ld  output  12  latest left load-cell sample (A2D channel 0).
REQ-010 rght_ld  output  12  latest right load-cell sample (A2D channel 4).
REQ-011 batt  output  12  latest battery sample (A2D channel 5).
REQ-012 vld  output  1  single-cycle pulse: one of the three sample registers was updated this cycle.
REQ-013 busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 States: IDLE, CMD, GAP, READ; busy = (state != IDLE).
REQ-015 Channel pointer rotates 0 -> 4 -> 5 -> 0; it advances only on completion of READ.
REQ-016 cmd = {2'b00, ch[2:0], 11'h000}; cmd is held stable from wrt until the matching done.
REQ-017 IDLE: nxt=1 -> wrt=1 for the same-cycle registered transition (wrt asserted in the cycle after nxt), state CMD.
REQ-018 CMD: wait for done; rd_data is ignored; on done -> GAP and load the gap counter with GAP_CYCLES.
REQ-019 GAP: decrement the counter each cycle; when it reaches 0, pulse wrt for one cycle with the same cmd -> READ.
REQ-020 READ: on done, capture rd_data[11:0] into the register of the current channel, pulse vld in the next cycle, advance the pointer -> IDLE.
REQ-021 nxt is ignored while busy; requests are not queued.
REQ-022 nxt and READ-done in the same cycle: the done is processed and the nxt is dropped.
REQ-023 done while IDLE or GAP is ignored; no state change and no register update.
REQ-024 rd_data[15:12] is discarded; outputs are unsigned 12-bit values with no sign extension.
REQ-025 End-to-end latency: nxt to vld = 2 SPI transactions + GAP_CYCLES + 3 clk.

Reset
REQ-026 rst_n low -> immediately: state IDLE, pointer channel 0, gap counter 0, wrt=0, vld=0, busy=0, cmd=16'h0000, lft_ld=rght_ld=batt=12'h000.
REQ-027 Reset asserted mid-transaction aborts the sequence; no partial register update; the first transaction after reset targets channel 0.

Configuration
REQ-028 Macro A2D_AVG_EN: when defined, each update writes (old + new + 1) >> 1 using 13-bit intermediate arithmetic; the first update after reset loads the raw sample (per-channel first-sample flag).
REQ-029 Without A2D_AVG_EN, each update writes the raw rd_data[11:0]; the averaging logic and first-sample flags are not present.

Verification
REQ-030 Reset, then nxt with an ADC model returning 0xC00 on ch0 -> cmd=16'h0000 on both wrt pulses, lft_ld=12'hC00, vld pulses once, pointer advances to 4.
REQ-031 Three nxt strobes spaced to finish, with left=0x123, right=0x456, batt=0xABC -> cmd sequence 0x0000, 0x2000, 0x2800; outputs 0x123/0x456/0xABC; the fourth nxt targets ch0 again.
REQ-032 nxt re-pulsed while busy (in CMD, GAP and READ) -> exactly 2 wrt pulses and 1 vld per accepted request.
REQ-033 rst_n pulsed low while in READ -> all outputs 0 at once; the next nxt issues cmd=16'h0000.
REQ-034 GAP_CYCLES=5 -> exactly 5 clk cycles from the first done to the second wrt.
REQ-035 A2D_AVG_EN defined, ch0 samples 0x100 then 0x201 -> lft_ld=0x100, then 0x181.
